// File: rtl/reg_share_arbiter.sv
// Round-robin access controller for one shared DATA_W-bit register among N_REQ requesters.
// Optional macro SHARE_LOCK_EN adds i_lock, letting the owner suppress the MAX_HOLD timeout.
module reg_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic [N_REQ-1:0]                              i_req,
  input  logic [N_REQ-1:0]                              i_we,
  input  logic [N_REQ*DATA_W-1:0]                       i_wdata,
`ifdef SHARE_LOCK_EN
  input  logic                                          i_lock,
`endif
  output logic [N_REQ-1:0]                              o_gnt,
  output logic [((N_REQ > 2) ? $clog2(N_REQ) : 1)-1:0]  o_gnt_id,
  output logic                                          o_busy,
  output logic [DATA_W-1:0]                             o_q,
  output logic [N_REQ-1:0]                              o_wr_ack
);

  localparam int IDW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [HCW-1:0]    hcnt;
  logic              found;
  logic [IDW-1:0]    pick;
  logic              own_req;
  logic              own_we;
  logic              lock_hold;
  logic [DATA_W-1:0] own_wdata;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // First active requester at or above ptr, wrapping past N_REQ-1.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  assign own_req   = i_req[o_gnt_id];
  assign own_we    = i_we[o_gnt_id];
  assign own_wdata = i_wdata[o_gnt_id*DATA_W +: DATA_W];

`ifdef SHARE_LOCK_EN
  assign lock_hold = i_lock & own_req;
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hcnt     <= '0;
      o_gnt    <= '0;
      o_gnt_id <= '0;
      o_busy   <= 1'b0;
      o_q      <= '0;
      o_wr_ack <= '0;
    end else begin
      o_wr_ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            o_gnt    <= onehot(pick);
            o_gnt_id <= pick;
            o_busy   <= 1'b1;
            hcnt     <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A write on the releasing edge still lands, as long as the owner is requesting.
          if (own_req && own_we) begin
            o_q      <= own_wdata;
            o_wr_ack <= onehot(o_gnt_id);
          end
          if (!own_req || (hcnt == HOLD_LAST && !lock_hold)) begin
            o_gnt  <= '0;
            o_busy <= 1'b0;
            ptr    <= (o_gnt_id == LAST_ID) ? '0 : o_gnt_id + 1'b1;
            state  <= IDLE;
          end else if (hcnt != HOLD_LAST) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: reset, writes, round-robin rotation, early release, fault filtering.
module tb_reg_share_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;

  logic                      clk;
  logic                      rst;
  logic [N_REQ-1:0]          req;
  logic [N_REQ-1:0]          we;
  logic [N_REQ*DATA_W-1:0]   wdata;
  logic                      lock;
  logic [N_REQ-1:0]          gnt;
  logic [1:0]                gnt_id;
  logic                      busy;
  logic [DATA_W-1:0]         q;
  logic [N_REQ-1:0]          wr_ack;

  int n_checks;
  int n_errors;

  reg_share_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_HOLD(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_we     (we),
    .i_wdata  (wdata),
`ifdef SHARE_LOCK_EN
    .i_lock   (lock),
`endif
    .o_gnt    (gnt),
    .o_gnt_id (gnt_id),
    .o_busy   (busy),
    .o_q      (q),
    .o_wr_ack (wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt),    32'h0);
    check({tag, "_id"},   32'(gnt_id), 32'h0);
    check({tag, "_busy"}, 32'(busy),   32'h0);
    check({tag, "_q"},    32'(q),      32'h0);
    check({tag, "_ack"},  32'(wr_ack), 32'h0);
  endtask

  initial begin
    logic [N_REQ-1:0] order [5];
    n_checks = 0;
    n_errors = 0;
    lock  = 1'b0;
    rst   = 1'b1;
    req   = 4'b1111;
    we    = 4'b1111;
    wdata = 32'hFFFF_FFFF;

    // reset holds everything at zero despite requests and writes
    tick(); check_idle_zero("rst1");
    tick(); check_idle_zero("rst2");
    rst = 1'b0; req = '0; we = '0;
    tick(); check_idle_zero("rst_rel");

    // single requester write
    req = 4'b0001; we = 4'b0001; wdata = 32'h0000_00A5;
    tick();
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_busy", 32'(busy), 32'h1);
    check("t2_q_before", 32'(q), 32'h0);
    tick();
    check("t2_q", 32'(q), 32'hA5);
    check("t2_ack", 32'(wr_ack), 32'h1);
    we = '0;
    tick();
    check("t2_ack_low", 32'(wr_ack), 32'h0);
    check("t2_q_hold", 32'(q), 32'hA5);
    req = '0;
    tick();
    check("t2_rel_gnt", 32'(gnt), 32'h0);
    check("t2_rel_id", 32'(gnt_id), 32'h0);

    // full rotation with timeout, write honoured on the timeout edge of owner 2
    rst = 1'b1; tick(); rst = 1'b0;
    check("t3_rst_q", 32'(q), 32'h0);
    req = 4'b1111; we = '0; wdata = '0;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int e = 0; e < 5; e++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        check($sformatf("t3_gnt_o%0d_c%0d", e, c), 32'(gnt), 32'(order[e]));
        if (e == 2 && c == 7) begin
          we = 4'b0100; wdata = 32'h0077_0000;
        end
      end
      tick();
      check($sformatf("t3_gap_o%0d", e), 32'(gnt), 32'h0);
      check($sformatf("t3_id_o%0d", e), 32'(gnt_id), 32'(e % 4));
      if (e == 2) begin
        check("t3_timeout_wr_q", 32'(q), 32'h77);
        check("t3_timeout_wr_ack", 32'(wr_ack), 32'h4);
        we = '0;
      end
    end
    req = '0;
    tick();

    // early release, pointer skips the idle requester 1
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t4_gnt_c%0d", c), 32'(gnt), 32'h1);
    end
    req = 4'b0100; we = 4'b0001; wdata = 32'h0000_00EE;
    tick();
    check("t4_gap_gnt", 32'(gnt), 32'h0);
    check("t4_gap_busy", 32'(busy), 32'h0);
    check("t4_dropped_wr_q", 32'(q), 32'h0);
    check("t4_dropped_wr_ack", 32'(wr_ack), 32'h0);
    we = '0;
    tick();
    check("t4_next_gnt", 32'(gnt), 32'h4);
    check("t4_next_id", 32'(gnt_id), 32'h2);

    // owner write, non-owner write ignored, reset mid-grant
    we = 4'b0100; wdata = 32'h005A_0000;
    tick();
    check("t5_own_q", 32'(q), 32'h5A);
    check("t5_own_ack", 32'(wr_ack), 32'h4);
    we = 4'b0010; wdata = 32'h0000_3C00;
    tick();
    check("t5_other_q", 32'(q), 32'h5A);
    check("t5_other_ack", 32'(wr_ack), 32'h0);
    check("t5_still_gnt", 32'(gnt), 32'h4);
    rst = 1'b1; we = 4'b0100; wdata = 32'h0011_0000;
    tick();
    check_idle_zero("t5_rst");
    rst = 1'b0; req = '0; we = 4'b1111; wdata = 32'hFFFF_FFFF;
    tick();
    check("t5_idle_wr_q", 32'(q), 32'h0);
    check("t5_idle_wr_ack", 32'(wr_ack), 32'h0);
    we = '0;

`ifdef SHARE_LOCK_EN
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0011; lock = 1'b1;
    for (int c = 0; c < 22; c++) begin
      tick();
      check($sformatf("t6_lock_c%0d", c), 32'(gnt), 32'h1);
    end
    req = 4'b0010;
    tick();
    check("t6_gap", 32'(gnt), 32'h0);
    tick();
    check("t6_next", 32'(gnt), 32'h2);
    lock = 1'b0; req = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
